led_ctrl: RTL and testbench
===========================

# led_ctrl

Single-LED mode controller driven by the debounced key event pulse: each press steps the LED through OFF → ON → SLOW blink → FAST blink → OFF. It is the output-side consumer of the key front end. It turns button events into a visible indicator and holds all LED timing locally.

## Interface
- `SLOW_HALF`, default 25_000_000: half-period of slow blink, in sys_clk cycles (1 Hz at 50 MHz); legal ≥ 1.
- `FAST_HALF`, default 6_250_000: half-period of fast blink, in sys_clk cycles (4 Hz at 50 MHz); legal ≥ 1.
- `CNT_W`, default 25: blink counter width; must hold max(SLOW_HALF, FAST_HALF) − 1.
- `sys_clk` in 1: single clock; all logic on the rising edge.
- `sys_rst` in 1: asynchronous, active-low reset.
- `key_press` in 1: press event, synchronous to sys_clk; each cycle it is high counts as one press. Upstream delivers single-cycle pulses.
- `led` out 1: LED drive, active-high, registered.
- `mode` out 2: current mode, registered; 0=OFF, 1=ON, 2=SLOW, 3=FAST.

## Operation
- State: `mode` register (4 states), blink counter `cnt[CNT_W-1:0]`, blink phase bit `ph`.
- Mode transitions happen only on key_press=1: OFF→ON→SLOW→FAST→OFF (mode+1, wrapping 3→0). With no press, the mode holds.
- On any mode change edge:
  - `cnt` ← 0, `ph` ← 1.
  - `led` ← 0 if the new mode is OFF, else 1.
- OFF: led=0, cnt held at 0.
- ON: led=1, cnt held at 0.
- SLOW/FAST, with no press in the cycle and H = SLOW_HALF or FAST_HALF per the current mode:
  - If cnt == H−1: cnt ← 0, ph ← ~ph, led ← ~ph.
  - Else: cnt ← cnt+1, led unchanged.
- The counter compares against the H of the current mode only; there is no carry-over between modes.
- A press on the same edge as a blink toggle: the mode change wins. The new mode's entry values are loaded and the toggle is discarded.
- Back-to-back presses on consecutive cycles: each advances one mode. Four consecutive pulses return to the starting mode with cnt=0, ph=1.
- key_press is already synchronous; no internal synchronizer or edge detect.

## Timing
- Reset (sys_rst low, asynchronous, effective immediately and mid-blink): mode=0, led=0, cnt=0, ph=1. Release is synchronous to the next edge; the first press is honoured on the first edge with sys_rst high.
- Latency: press sampled at edge E → mode and led reflect the new mode after E (1 cycle, no extra pipeline).
- Blink, with the mode entered at edge E:
  - led=1 during (E, E+H].
  - led toggles at E+H, E+2H, E+3H, …
  - Period 2H, 50% duty.
- H=1: led toggles every cycle after entry.
- `mode` and `led` are glitch-free register outputs; no combinational path from key_press to either.

## Test plan
- Reset: assert sys_rst low mid-FAST blink with led=1 → led=0 and mode=0 immediately (before the next edge); after release with no press, both hold 0 for 100 cycles.
- Mode cycling (SLOW_HALF=8, FAST_HALF=3): single-cycle pulses 20 cycles apart → mode sequence 1,2,3,0,1. At each press edge, led=1 for entry into ON/SLOW/FAST and 0 for entry into OFF.
- Blink timing (SLOW_HALF=8): enter SLOW at edge E → led=1 through E+8, 0 after E+8, 1 after E+16. This holds for 10 periods, with exactly 8 cycles per level.
- Collision (FAST_HALF=3): press on the exact edge where FAST would toggle → mode=0, led=0, no toggle seen. Press again 5 cycles later → mode=1, led=1.
- Back-to-back presses: key_press high for 4 consecutive cycles starting from OFF → mode steps 1,2,3,0 on successive edges and ends at 0 with led=0.
- Edge parameter (FAST_HALF=1): enter FAST → led alternates 1,0,1,0 every cycle after entry; a press then returns to OFF with led=0.

Source files
------------

// File: rtl/led_ctrl.sv
// Single-LED mode controller: each key_press steps OFF -> ON -> SLOW -> FAST -> OFF.
// Latency: press sampled at edge E, mode/led show the new mode right after E (1 cycle).
// Backpressure: none; every key_press cycle is accepted unconditionally.
module led_ctrl #(
  parameter int SLOW_HALF = 25_000_000,
  parameter int FAST_HALF = 6_250_000,
  parameter int CNT_W     = 25
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_press,
  output logic       led,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    M_OFF  = 2'd0,
    M_ON   = 2'd1,
    M_SLOW = 2'd2,
    M_FAST = 2'd3
  } mode_t;

  // Terminal counts: the counter wraps after H cycles of the active blink mode.
  localparam logic [CNT_W-1:0] SLOW_TOP = CNT_W'(SLOW_HALF - 1);
  localparam logic [CNT_W-1:0] FAST_TOP = CNT_W'(FAST_HALF - 1);

  mode_t            mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ph_q, ph_d;
  logic             led_q, led_d;
  logic [CNT_W-1:0] top;

  // State registers; reset parks the LED dark in OFF with the phase primed to 1.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      mode_q <= M_OFF;
      cnt_q  <= '0;
      ph_q   <= 1'b1;
      led_q  <= 1'b0;
    end else begin
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      ph_q   <= ph_d;
      led_q  <= led_d;
    end
  end

  // Next-state: a press always wins over a blink toggle in the same cycle.
  always_comb begin
    mode_d = mode_q;
    cnt_d  = cnt_q;
    ph_d   = ph_q;
    led_d  = led_q;
    top    = (mode_q == M_SLOW) ? SLOW_TOP : FAST_TOP;
    if (key_press) begin
      mode_d = mode_t'(mode_q + 2'd1);
      cnt_d  = '0;
      ph_d   = 1'b1;
      led_d  = (mode_d != M_OFF);
    end else begin
      case (mode_q)
        M_OFF: begin
          cnt_d = '0;
          led_d = 1'b0;
        end
        M_ON: begin
          cnt_d = '0;
          led_d = 1'b1;
        end
        default: begin
          if (cnt_q == top) begin
            cnt_d = '0;
            ph_d  = ~ph_q;
            led_d = ~ph_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: two instances (SLOW=8/FAST=3 and SLOW=5/FAST=1) against an age-based model.
// Latency: expected values refer to the state just after each rising edge.
// Backpressure: not applicable; presses are driven freely.
module tb_led_ctrl;

  logic       sys_clk;
  logic       sys_rst;
  logic       key_a, key_b;
  logic       led_a, led_b;
  logic [1:0] mode_a, mode_b;

  int checks = 0;
  int errors = 0;

  // Reference model: mode plus number of edges since the mode was entered.
  int mode_m [2];
  int age_m  [2];
  int hs     [2] = '{8, 5};
  int hf     [2] = '{3, 1};

  led_ctrl #(.SLOW_HALF(8), .FAST_HALF(3), .CNT_W(4)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_press(key_a), .led(led_a), .mode(mode_a)
  );

  led_ctrl #(.SLOW_HALF(5), .FAST_HALF(1), .CNT_W(3)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .key_press(key_b), .led(led_b), .mode(mode_b)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  function automatic int exp_led(input int i);
    case (mode_m[i])
      0:       return 0;
      1:       return 1;
      2:       return ((age_m[i] / hs[i]) % 2 == 0) ? 1 : 0;
      default: return ((age_m[i] / hf[i]) % 2 == 0) ? 1 : 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("a_mode", {30'd0, mode_a}, mode_m[0]);
    check("a_led",  {31'd0, led_a},  exp_led(0));
    check("b_mode", {30'd0, mode_b}, mode_m[1]);
    check("b_led",  {31'd0, led_b},  exp_led(1));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mode_m[i] = 0;
      age_m[i]  = 0;
    end
  endtask

  // One clock edge: drive presses, advance the model, check just after the edge.
  task automatic tick(input bit pa, input bit pb);
    bit p [2];
    p[0] = pa;
    p[1] = pb;
    key_a = pa;
    key_b = pb;
    @(posedge sys_clk);
    for (int i = 0; i < 2; i++) begin
      if (!sys_rst) begin
        mode_m[i] = 0;
        age_m[i]  = 0;
      end else if (p[i]) begin
        mode_m[i] = (mode_m[i] + 1) % 4;
        age_m[i]  = 0;
      end else begin
        age_m[i]++;
      end
    end
    #1;
    key_a = 1'b0;
    key_b = 1'b0;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0);
  endtask

  initial begin
    sys_rst = 1'b0;
    key_a   = 1'b0;
    key_b   = 1'b0;
    model_reset();

    // Reset state, then release between edges.
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    check("rst_led_a", {31'd0, led_a}, 0);
    sys_rst = 1'b1;
    idle(3);

    // Mode cycling with presses 20 cycles apart: 1,2,3,0,1.
    for (int n = 0; n < 5; n++) begin
      tick(1'b1, 1'b0);
      check("cyc_mode", {30'd0, mode_a}, (n + 1) % 4);
      check("cyc_entry_led", {31'd0, led_a}, ((n + 1) % 4 == 0) ? 0 : 1);
      idle(19);
    end

    // Blink timing in SLOW for 10 full periods, level lengths tracked explicitly.
    tick(1'b1, 1'b0);
    check("slow_mode", {30'd0, mode_a}, 2);
    begin
      int run;
      logic prev;
      run  = 1;
      prev = led_a;
      for (int k = 0; k < 160; k++) begin
        tick(1'b0, 1'b0);
        if (led_a === prev) begin
          run++;
        end else begin
          check("slow_level_len", run, 8);
          run  = 1;
          prev = led_a;
        end
      end
    end

    // Collision: press on the edge where FAST would first toggle.
    tick(1'b1, 1'b0);
    check("fast_mode", {30'd0, mode_a}, 3);
    idle(2);
    tick(1'b1, 1'b0);
    check("coll_mode", {30'd0, mode_a}, 0);
    check("coll_led",  {31'd0, led_a},  0);
    idle(4);
    tick(1'b1, 1'b0);
    check("coll_next_mode", {30'd0, mode_a}, 1);
    check("coll_next_led",  {31'd0, led_a},  1);

    // Back-to-back presses from OFF.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("b2b_start", {30'd0, mode_a}, 0);
    idle(5);
    for (int n = 0; n < 4; n++) begin
      tick(1'b1, 1'b0);
      check("b2b_mode", {30'd0, mode_a}, (n + 1) % 4);
    end
    check("b2b_end_led", {31'd0, led_a}, 0);
    idle(3);

    // H=1 on the second instance: enter FAST, led alternates each cycle.
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("h1_mode", {30'd0, mode_b}, 3);
    check("h1_entry", {31'd0, led_b}, 1);
    for (int k = 1; k <= 6; k++) begin
      tick(1'b0, 1'b0);
      check("h1_alt", {31'd0, led_b}, (k % 2 == 0) ? 1 : 0);
    end
    tick(1'b0, 1'b1);
    check("h1_off_mode", {30'd0, mode_b}, 0);
    check("h1_off_led",  {31'd0, led_b},  0);

    // Asynchronous reset mid-FAST while led is high.
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("pre_rst_led", {31'd0, led_a}, 1);
    #2;
    sys_rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_mode", {30'd0, mode_a}, 0);
    check("async_rst_led",  {31'd0, led_a},  0);
    tick(1'b0, 1'b0);
    sys_rst = 1'b1;
    idle(100);

    // Randomized presses on both instances.
    for (int k = 0; k < 3000; k++) begin
      tick($urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
